// File: rtl/nibble_link_pkg.sv
// Shared definitions for the 4-bit nibble operand link (transmit and receive sides).
package nibble_link_pkg;
    localparam int NIBBLE_W       = 4;
    localparam int NIB_PER_OP_DEF = 3;

    typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} tx_state_t;
endpackage

// File: rtl/operand_nibble_tx.sv
// Nibble link transmitter: captures an operand pair and streams it MSB-first,
// operand A then operand B, with per-nibble valid/ready and frame markers.
module operand_nibble_tx
    import nibble_link_pkg::*;
#(
    parameter int NIB_PER_OP = NIB_PER_OP_DEF,
    parameter int FCNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NIBBLE_W*NIB_PER_OP-1:0] op_a,
    input  logic [NIBBLE_W*NIB_PER_OP-1:0] op_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NIBBLE_W-1:0]            sample,
    output logic                           sof,
    output logic                           eof,
    output logic                           busy,
    output logic [FCNT_W-1:0]              frame_cnt
);
    localparam int OP_W  = NIBBLE_W * NIB_PER_OP;
    localparam int IDX_W = (NIB_PER_OP > 1) ? $clog2(NIB_PER_OP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_PER_OP - 1);

    tx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [OP_W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]   cur_op;
    logic              xfer, last;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        xfer    = out_valid && out_ready;
        last    = (idx_q == LAST_IDX);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEND_A;
                    idx_d   = '0;
                    opa_d   = op_a;
                    opb_d   = op_b;
                end
            end
            SEND_A: begin
                if (xfer) begin
                    if (last) begin
                        state_d = SEND_B;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SEND_B: begin
                if (xfer) begin
                    if (last) begin
                        cnt_d = cnt_q + FCNT_W'(1);
                        idx_d = '0;
                        // eof transfer doubles as a capture slot so frames chain without a bubble
                        if (in_valid) begin
                            state_d = SEND_A;
                            opa_d   = op_a;
                            opb_d   = op_b;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = busy;
        sof       = (state_q == SEND_A) && (idx_q == '0);
        eof       = (state_q == SEND_B) && (idx_q == LAST_IDX);
        in_ready  = (state_q == IDLE) || (eof && out_ready);
        cur_op    = (state_q == SEND_B) ? opb_q : opa_q;
        sample    = '0;
        if (out_valid)
            sample = cur_op[NIBBLE_W*(NIB_PER_OP-1-int'(idx_q)) +: NIBBLE_W];
        frame_cnt = cnt_q;
    end
endmodule

// File: tb/tb_operand_nibble_tx.sv
// Directed bench for operand_nibble_tx: ordering, backpressure, chaining, reset and counter wrap.
module tb_operand_nibble_tx;
    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] op_a = '0;
    logic [11:0] op_b = '0;
    logic        in_ready, out_valid, sof, eof, busy;
    logic [3:0]  sample;
    logic [7:0]  frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    operand_nibble_tx #(.NIB_PER_OP(3), .FCNT_W(8)) dut (
        .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .sample(sample), .sof(sof), .eof(eof), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        #12;
        n_vec++;
        if (out_valid !== 1'b0 || sample !== 4'h0 || sof !== 1'b0 || eof !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b s=%h sof=%b eof=%b busy=%b cnt=%0d, want all 0",
                     out_valid, sample, sof, eof, busy, frame_cnt);
        end
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp [6] = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3};
        @(negedge clk);
        in_valid = 1'b1; op_a = 12'hABC; op_b = 12'h123; out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_vec++;
            if (out_valid !== 1'b1 || sample !== exp[i] || sof !== 1'(i == 0) || eof !== 1'(i == 5)) begin
                n_err++;
                $display("FAIL basic_nib%0d: got v=%b s=%h sof=%b eof=%b, want v=1 s=%h sof=%b eof=%b",
                         i, out_valid, sample, sof, eof, exp[i], i == 0, i == 5);
            end
            if (i == 2) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_in_ready_busy: got %b want 0", in_ready);
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        exp_cnt++;
        n_vec++;
        if (frame_cnt !== 8'(exp_cnt) || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end: got cnt=%0d v=%b busy=%b, want cnt=%0d v=0 busy=0",
                     frame_cnt, out_valid, busy, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp [6] = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3};
        @(negedge clk);
        in_valid = 1'b1; op_a = 12'hABC; op_b = 12'h123; out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                n_vec++;
                if (out_valid !== 1'b1 || sample !== exp[i] || sof !== 1'(i == 0) || eof !== 1'(i == 5)) begin
                    n_err++;
                    $display("FAIL bp_nib%0d_cyc%0d: got v=%b s=%h sof=%b eof=%b, want v=1 s=%h sof=%b eof=%b",
                             i, c, out_valid, sample, sof, eof, exp[i], i == 0, i == 5);
                end
                out_ready = (c == 2);
                @(posedge clk);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        exp_cnt++;
        n_vec++;
        if (frame_cnt !== 8'(exp_cnt) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: got cnt=%0d v=%b, want cnt=%0d v=0", frame_cnt, out_valid, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp [12] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h1,
                                 4'h8, 4'h0, 4'h0, 4'h7, 4'hF, 4'hF};
        @(negedge clk);
        in_valid = 1'b1; op_a = 12'hFFF; op_b = 12'h001; out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin op_a = 12'h800; op_b = 12'h7FF; end
            if (i == 6) in_valid = 1'b0;
            n_vec++;
            if (out_valid !== 1'b1 || sample !== exp[i] || sof !== 1'(i % 6 == 0) || eof !== 1'(i % 6 == 5)) begin
                n_err++;
                $display("FAIL b2b_nib%0d: got v=%b s=%h sof=%b eof=%b, want v=1 s=%h sof=%b eof=%b",
                         i, out_valid, sample, sof, eof, exp[i], i % 6 == 0, i % 6 == 5);
            end
            if (i == 5) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_in_ready_eof: got %b want 1", in_ready);
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        exp_cnt += 2;
        n_vec++;
        if (frame_cnt !== 8'(exp_cnt) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got cnt=%0d v=%b, want cnt=%0d v=0", frame_cnt, out_valid, exp_cnt);
        end
    endtask

    task automatic test_ignore_busy();
        logic [3:0] exp [6] = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3};
        @(negedge clk);
        in_valid = 1'b1; op_a = 12'hABC; op_b = 12'h123; out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            if (i == 2) op_a = 12'h555;
            n_vec++;
            if (busy !== 1'b1 || sample !== exp[i] || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL ignore_nib%0d: got busy=%b v=%b s=%h, want busy=1 v=1 s=%h",
                         i, busy, out_valid, sample, exp[i]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        exp_cnt++;
        n_vec++;
        if (frame_cnt !== 8'(exp_cnt) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_end: got cnt=%0d busy=%b, want cnt=%0d busy=0", frame_cnt, busy, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp [6] = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3};
        logic [3:0] exp2 [6] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
        @(negedge clk);
        in_valid = 1'b1; op_a = 12'hABC; op_b = 12'h123; out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_vec++;
            if (sample !== exp[i]) begin
                n_err++;
                $display("FAIL rstmid_nib%0d: got %h want %h", i, sample, exp[i]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        exp_cnt = 0;
        n_vec++;
        if (out_valid !== 1'b0 || sample !== 4'h0 || sof !== 1'b0 || eof !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL rstmid_async: got v=%b s=%h sof=%b eof=%b busy=%b cnt=%0d, want all 0",
                     out_valid, sample, sof, eof, busy, frame_cnt);
        end
        @(negedge clk);
        n_reset = 1'b1;
        in_valid = 1'b1; op_a = 12'h000; op_b = 12'hFFF;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_vec++;
            if (out_valid !== 1'b1 || sample !== exp2[i] || sof !== 1'(i == 0) || eof !== 1'(i == 5)) begin
                n_err++;
                $display("FAIL rstmid_new_nib%0d: got v=%b s=%h sof=%b eof=%b, want v=1 s=%h sof=%b eof=%b",
                         i, out_valid, sample, sof, eof, exp2[i], i == 0, i == 5);
            end
            @(posedge clk);
        end
        @(negedge clk);
        exp_cnt++;
        n_vec++;
        if (frame_cnt !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL rstmid_cnt: got %0d want %0d", frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        in_valid = 1'b1; op_a = 12'h3C5; op_b = 12'hA96; out_ready = 1'b1;
        @(posedge clk);
        for (int f = 0; f < 256; f++) begin
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (f == 255 && c == 0) begin
                    n_vec++;
                    if (frame_cnt !== 8'd255) begin
                        n_err++;
                        $display("FAIL wrap_pre: got %0d want 255", frame_cnt);
                    end
                end
                if (f == 255 && c == 5) begin
                    in_valid = 1'b0;
                    n_vec++;
                    if (eof !== 1'b1 || sample !== 4'h6) begin
                        n_err++;
                        $display("FAIL wrap_last_eof: got eof=%b s=%h want eof=1 s=6", eof, sample);
                    end
                end
                @(posedge clk);
            end
        end
        @(negedge clk);
        n_vec++;
        if (frame_cnt !== 8'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_post: got cnt=%0d v=%b want cnt=0 v=0", frame_cnt, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/operand_nibble_tx.md
# operand_nibble_tx

Transmit side of the 4-bit nibble operand link. Accepts two 12-bit operands in one parallel handshake and sends them as six nibbles, MSB-first: operand A [11:8], [7:4], [3:0], then operand B in the same order. This is the nibble order the summing receiver loads. Sits between the operand source (keypad/register logic) and the shared 4-bit sample bus. Per-nibble valid/ready handshake, frame markers and a completed-frame counter.

## Interface
- NIB_PER_OP, default 3: nibbles per operand; operand width is 4*NIB_PER_OP.
- FCNT_W, default 8: width of the completed-frame counter.
- clk  in  1  single clock; all state updates on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can capture an operand pair this cycle.
- op_a  in  4*NIB_PER_OP  first operand (sent first).
- op_b  in  4*NIB_PER_OP  second operand.
- out_valid  out  1  sample holds a valid nibble.
- out_ready  in  1  downstream accepts the nibble this cycle.
- sample  out  4  current nibble.
- sof  out  1  high with the first nibble of a frame (A MSB).
- eof  out  1  high with the last nibble of a frame (B LSB).
- busy  out  1  frame in progress (state is not IDLE).
- frame_cnt  out  FCNT_W  number of completed frames, modulo 2^FCNT_W.

## Operation
- States: IDLE, SEND_A, SEND_B. Nibble index idx runs 0..NIB_PER_OP-1 within each operand.
- IDLE: in_ready=1, out_valid=0.
- IDLE, in_valid && in_ready: capture op_a and op_b into internal registers, go to SEND_A with idx=0.
- SEND_A/SEND_B: out_valid=1; sample is the selected nibble, idx 0 = bits [4*NIB_PER_OP-1 : 4*NIB_PER_OP-4].
- A nibble transfers on a cycle with out_valid && out_ready. It then advances idx.
- End of operand A: idx wraps to 0 and the state goes SEND_A -> SEND_B.
- End of operand B: the state goes to IDLE and frame_cnt increments.
- sof = (SEND_A && idx==0); eof = (SEND_B && idx==NIB_PER_OP-1). Both are combinational from state and idx, and are valid only while out_valid=1.
- Backpressure: while out_valid && !out_ready, the following are held stable: sample, sof, eof, state and idx.
- Zero-bubble chaining: in_ready is also 1 on the cycle the eof nibble transfers. If in_valid is 1 on that cycle, the new pair is captured and the next state is SEND_A, idx=0 (not IDLE). frame_cnt still increments.
- in_valid while busy and not on an eof transfer is ignored: no capture, and op_a/op_b are don't-care. The source must hold its data until in_ready.
- frame_cnt wraps from 2^FCNT_W-1 to 0 with no flag.
- Operand values are not modified (no arithmetic). Operands change only at capture.

## Timing
- Reset (n_reset=0, asynchronous) sets:
  - state=IDLE, idx=0;
  - out_valid=0, sample=0, sof=0, eof=0, busy=0;
  - frame_cnt=0, captured operands=0.
  - in_ready=1 once n_reset is released.
- Reset mid-frame drops the frame: no eof, no counter increment, and no remaining nibbles are sent.
- Latency: capture on edge N; the first nibble (sof) is valid from edge N to edge N+1.
- Minimum frame length is 2*NIB_PER_OP cycles, which is 6 with out_ready held high.
- Back-to-back frames with out_ready=1 and in_valid=1 give continuous out_valid with no idle cycle. eof of frame k is followed directly by sof of frame k+1.
- sample, out_valid, sof and eof are driven from registers or from registered state/idx only; there is no combinational path from out_ready or in_valid to these outputs.
- in_ready depends combinationally on out_ready (eof transfer term) only.

## Structure
- Shared package nibble_link_pkg holds:
  - NIBBLE_W=4;
  - enum tx_state_t {IDLE, SEND_A, SEND_B};
  - the default NIB_PER_OP, which the receiver side also uses.
- No sub-module needed. The nibble select is an indexed part-select of the active operand register; the counter is inline.

## Test plan
- op_a=0xABC, op_b=0x123, out_ready=1 -> sample A,B,C,1,2,3 on six consecutive cycles; sof with A only; eof with 3 only; frame_cnt 0->1.
- Same frame, out_ready low 2 cycles on each nibble -> sequence unchanged; each nibble held 3 cycles; no duplicate or skipped nibble.
- Two pairs (0xFFF,0x001) then (0x800,0x7FF), in_valid continuously high, out_ready=1 -> 12 contiguous valid cycles F,F,F,0,0,1,8,0,0,7,F,F; frame_cnt=2.
- in_valid pulsed with op_a=0x555 during the third nibble of frame 0xABC/0x123 -> pulse ignored; output stays A,B,C,1,2,3; busy=1 throughout.
- n_reset asserted after the 4th nibble -> all outputs 0 immediately; frame_cnt=0; after release, a new frame 0x000/0xFFF sends 0,0,0,F,F,F.
- FCNT_W=8: run 256 frames -> frame_cnt wraps 255->0 on the 256th eof transfer.
